// File: rtl/signal_change_logger.sv
`default_nettype none
// ============================================================================
// Module   : signal_change_logger
// Brief    : Timestamps edges on NUM_CH status signals into an event FIFO that
//            is drained over a valid/ready port. Define SIG_SYNC_EN to add a
//            2-flop input synchronizer for asynchronous inputs.
// Revision : 1.0 - initial release
// ============================================================================
module signal_change_logger #(
  parameter int NUM_CH     = 3,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int OVF_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              sig_in,
  input  logic [NUM_CH-1:0]              ch_mask,
  input  logic                           enable,
  output logic                           event_valid,
  input  logic                           event_ready,
  output logic [TS_WIDTH+2*NUM_CH-1:0]   event_data,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [OVF_WIDTH-1:0]           ovf_count,
  input  logic                           ovf_clear
);

  localparam int c_DW = TS_WIDTH + 2 * NUM_CH;
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_LW = c_AW + 1;

  logic [TS_WIDTH-1:0]  r_ts;
  logic [NUM_CH-1:0]    r_prev;
  logic                 r_armed;
  logic [c_DW-1:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr;
  logic [c_AW-1:0]      r_rd;
  logic [c_LW-1:0]      r_level;
  logic [OVF_WIDTH-1:0] r_ovf;

  logic [NUM_CH-1:0]    w_s;
  logic                 w_fill_done;
  logic [NUM_CH-1:0]    w_chg;
  logic                 w_push_req;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_drop;

`ifdef SIG_SYNC_EN
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [1:0]        r_fill;

  // Arming is held off until r_sync2 carries a real sample of sig_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_fill  <= 2'd0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      if (r_fill != 2'd2) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

  assign w_s         = r_sync2;
  assign w_fill_done = (r_fill == 2'd2);
`else
  assign w_s         = sig_in;
  assign w_fill_done = 1'b1;
`endif

  assign w_chg      = (w_s ^ r_prev) & ch_mask;
  assign w_push_req = r_armed & enable & (|w_chg);
  assign w_full     = (r_level == c_LW'(FIFO_DEPTH));
  assign w_pop      = (r_level != '0) & event_ready;
  // A full FIFO still accepts a push when the head leaves at the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts    <= '0;
      r_prev  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_ts   <= r_ts + 1'b1;
      r_prev <= w_s;
      if (w_fill_done) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {r_ts, w_chg, w_s};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  // Clear wins first, then a drop in the same cycle is still counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= '0;
    end else if (ovf_clear) begin
      r_ovf <= w_drop ? OVF_WIDTH'(1) : '0;
    end else if (w_drop && !(&r_ovf)) begin
      r_ovf <= r_ovf + 1'b1;
    end
  end

  assign event_valid = (r_level != '0);
  assign event_data  = event_valid ? r_mem[r_rd] : '0;
  assign fifo_level  = r_level;
  assign ovf_count   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_signal_change_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_signal_change_logger
// Brief    : Directed self-checking bench for signal_change_logger.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signal_change_logger;

  logic        clk;
  logic        reset;
  logic [2:0]  sig_in;
  logic [2:0]  ch_mask;
  logic        enable;
  logic        event_valid;
  logic        event_ready;
  logic [21:0] event_data;
  logic [3:0]  fifo_level;
  logic [7:0]  ovf_count;
  logic        ovf_clear;

  logic        reset2;
  logic [2:0]  sig2;
  logic        valid2;
  logic        ready2;
  logic [13:0] data2;
  logic [1:0]  level2;
  logic [1:0]  ovf2;

  int n_cmp;
  int n_err;

  signal_change_logger #(
    .NUM_CH(3), .TS_WIDTH(16), .FIFO_DEPTH(8), .OVF_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .ch_mask(ch_mask),
    .enable(enable), .event_valid(event_valid), .event_ready(event_ready),
    .event_data(event_data), .fifo_level(fifo_level), .ovf_count(ovf_count),
    .ovf_clear(ovf_clear)
  );

  // Narrow timestamp, shallow FIFO and tiny overflow counter for wrap/saturation.
  signal_change_logger #(
    .NUM_CH(3), .TS_WIDTH(8), .FIFO_DEPTH(2), .OVF_WIDTH(2)
  ) dut2 (
    .clk(clk), .reset(reset2), .sig_in(sig2), .ch_mask(3'b111),
    .enable(1'b1), .event_valid(valid2), .event_ready(ready2),
    .event_data(data2), .fifo_level(level2), .ovf_count(ovf2),
    .ovf_clear(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; sig_in = 3'b101; ch_mask = 3'b111; enable = 1'b1;
    event_ready = 1'b0; ovf_clear = 1'b0;
    reset2 = 1'b1; sig2 = 3'b000; ready2 = 1'b0;

    // Reset state
    step(2);
    check("rst_valid", event_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", ovf_count, 0);
    check("rst_data", event_data, 0);

    // Static non-zero inputs at release must not produce an event
    reset = 1'b0;
    step(20);
    check("quiet_valid", event_valid, 0);
    check("quiet_level", fifo_level, 0);

    // Single event at edge 10 after arming
    reset = 1'b1; sig_in = 3'b000; event_ready = 1'b1;
    step();
    reset = 1'b0;
    step(10);
    sig_in = 3'b010;
    step();
    check("ev10_valid", event_valid, 1);
    check("ev10_data", event_data, {16'd10, 3'b010, 3'b010});
    check("ev10_level", fifo_level, 1);
    step();
    check("ev10_one_cycle", event_valid, 0);

    // Ten toggles into an 8-deep FIFO: timestamps 12..21, last two dropped
    event_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sig_in[0] = ~sig_in[0];
      step();
    end
    check("full_level", fifo_level, 8);
    check("full_ovf", ovf_count, 2);
    check("full_head", event_data, {16'd12, 3'b001, 3'b011});

    // Full with simultaneous push and pop
    event_ready = 1'b1;
    sig_in[0] = ~sig_in[0];
    step();
    check("pushpop_level", fifo_level, 8);
    check("pushpop_ovf", ovf_count, 2);

    for (int i = 0; i < 8; i++) begin
      check("drain_valid", event_valid, 1);
      check("drain_ts", event_data[21:6], (i < 7) ? 16'(13 + i) : 16'd22);
      step();
    end
    check("drained_valid", event_valid, 0);
    check("drained_level", fifo_level, 0);

    // ovf_clear alone, then together with a drop
    event_ready = 1'b0; ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    check("clr_ovf", ovf_count, 0);
    for (int i = 0; i < 10; i++) begin
      sig_in[0] = ~sig_in[0];
      step();
    end
    check("refill_ovf", ovf_count, 2);
    ovf_clear = 1'b1;
    sig_in[0] = ~sig_in[0];
    step();
    ovf_clear = 1'b0;
    check("clr_drop_ovf", ovf_count, 1);
    check("clr_drop_level", fifo_level, 8);
    event_ready = 1'b1;
    step(8);
    check("clr_drained", fifo_level, 0);

    // Channel mask
    ch_mask = 3'b000; sig_in = 3'b000;
    step();
    check("mask0_valid", event_valid, 0);
    ch_mask = 3'b011; sig_in = 3'b100;
    step();
    check("mask_ch2_valid", event_valid, 0);
    sig_in = 3'b001;
    step();
    check("mask_ch02_valid", event_valid, 1);
    check("mask_ch02_low", event_data[5:0], {3'b001, 3'b001});
    step();
    check("mask_popped", event_valid, 0);

    // Disabled logging, then re-enable without reporting a stale edge
    ch_mask = 3'b111; enable = 1'b0; sig_in = 3'b110;
    step();
    check("dis_valid", event_valid, 0);
    enable = 1'b1;
    step();
    check("reen_valid", event_valid, 0);

    // Reset mid-operation discards queued events
    event_ready = 1'b0; sig_in = 3'b111;
    step();
    sig_in = 3'b000;
    step();
    check("mid_level", fifo_level, 2);
    reset = 1'b1;
    step();
    check("midrst_level", fifo_level, 0);
    check("midrst_valid", event_valid, 0);
    check("midrst_data", event_data, 0);
    reset = 1'b0;
    step(2);
    check("midrst_rearm", event_valid, 0);

    // 8-bit timestamp wrap 8'hFF -> 8'h00, then overflow saturation at 2'b11
    reset2 = 1'b0;
    step(255);
    sig2 = 3'b001;
    step();
    sig2 = 3'b000;
    step();
    check("wrap_level", level2, 2);
    check("wrap_head_ff", data2, {8'hFF, 3'b001, 3'b001});
    for (int i = 0; i < 4; i++) begin
      sig2[0] = ~sig2[0];
      step();
    end
    check("sat_ovf", ovf2, 3);
    check("sat_head_stable", data2, {8'hFF, 3'b001, 3'b001});
    ready2 = 1'b1;
    step();
    ready2 = 1'b0;
    check("wrap_head_00", data2, {8'h00, 3'b001, 3'b000});
    check("wrap_level_after", level2, 1);
    check("wrap_valid", valid2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/signal_change_logger.md
Name: signal_change_logger

Overview:
- Synthesizable, parametrised successor to the bench-side LED change monitor.
- Watches NUM_CH single-bit status signals (LEDs, button, FSM flags) for edges.
- Each change is captured as a timestamped event in an internal FIFO.
- Events are drained through a valid/ready port by a CPU/APB register bridge or a debug UART.

Parameters:
- NUM_CH, 3, number of monitored single-bit channels (1..32).
- TS_WIDTH, 16, width of the free-running timestamp counter (8..32).
- FIFO_DEPTH, 8, event FIFO entries; power of 2, 2..256.
- OVF_WIDTH, 8, width of the saturating dropped-event counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sig_in  in  NUM_CH  monitored signals, synchronous to clk unless SIG_SYNC_EN is defined.
- ch_mask  in  NUM_CH  1 = channel may generate events.
- enable  in  1  logging enable.
- event_valid  out  1  FIFO head is valid.
- event_ready  in  1  consumer accepts head.
- event_data  out  TS_WIDTH+2*NUM_CH  {timestamp, changed_mask, new_value}.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.
- ovf_count  out  OVF_WIDTH  events dropped because the FIFO was full (saturating).
- ovf_clear  in  1  clears ovf_count.

Behaviour:
- Reset (synchronous, active-high; every register affected):
  - Cleared to 0: event_valid, fifo_level, ovf_count, timestamp, FIFO pointers, prev_q, armed.
  - event_data is don't-care while event_valid=0; the implementation drives 0 after reset.
- Timestamp:
  - TS_WIDTH counter, increments every clk while not in reset.
  - Wraps 2^TS_WIDTH-1 -> 0 silently.
- Arming:
  - First cycle after reset: prev_q <= s (s = sampled sig_in), armed <= 1, no event.
  - This prevents a spurious event from reset values.
- Change detect, at edge k with armed=1:
  - chg = (s ^ prev_q) & ch_mask.
  - prev_q <= s every cycle regardless of enable or mask.
  - If enable=1 and chg != 0: push {ts_k, chg, s}, where ts_k is the counter value before this edge's increment.
  - Multiple channels toggling in the same cycle produce one event with several chg bits set.
- Latency:
  - Sample at edge k into an empty FIFO: event_valid=1 after edge k, i.e. visible in cycle k+1.
  - No combinational path from sig_in to any output.
- Handshake:
  - Pop on event_valid & event_ready, at the same edge.
  - event_data stays stable while event_valid=1 and event_ready=0.
  - event_valid never drops without a pop.
- FIFO boundaries:
  - Full (fifo_level == FIFO_DEPTH) with push and no pop: event dropped, ovf_count++, saturating at all-ones.
  - Full with push and pop in the same cycle: push accepted, level unchanged, no overflow.
  - Empty with push and no pop: level becomes 1.
  - Empty with push and event_ready=1: no same-cycle bypass; the pop happens in a later cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- ovf_clear:
  - ovf_clear=1 sets ovf_count <= 0.
  - If a drop occurs in the same cycle, ovf_count <= 1 (the clear takes priority, then the drop is counted).
- enable=0:
  - No pushes; FIFO still drains.
  - prev_q keeps tracking, so re-enabling does not report stale edges.
- Reset mid-operation: all events, pointers and counters are discarded within the same edge; armed returns to 0.

Optional Feature:
- Macro: SIG_SYNC_EN.
- Defined:
  - sig_in passes through a 2-flop synchronizer per channel before sampling, for asynchronous inputs such as buttons.
  - Sample-to-event latency becomes 3 cycles from the input transition.
  - Synchronizer flops reset to 0.
  - Arming waits until the synchronizer is filled (3 cycles after reset release).
- Undefined:
  - sig_in is sampled directly.
  - Latency is 1 cycle, as specified in Behaviour.

Test Plan:
- Reset release with sig_in=3'b101, no toggles for 20 cycles -> event_valid stays 0, fifo_level=0.
- Toggle sig_in 3'b000 -> 3'b010 at edge 10 after arming, event_ready=1 -> one event, event_data = {16'd10, 3'b010, 3'b010} (timestamp counted from 0 at reset release); event_valid high for exactly one cycle.
- With event_ready=0, FIFO_DEPTH=8, generate 10 single-channel toggles -> fifo_level=8, ovf_count=2; drain yields 8 events with increasing timestamps.
- FIFO full, then toggle a channel with event_ready=1 in the same cycle -> fifo_level stays 8, ovf_count unchanged.
- ch_mask=3'b011, toggle ch2 only -> no event; toggle ch0 and ch2 together -> chg=3'b001.
- Timestamp wrap with TS_WIDTH=8: event at counter 255 then one at 0 -> timestamps reported 8'hFF then 8'h00.
- Additional checks:
  - ovf_clear together with a drop -> ovf_count=1.
  - With SIG_SYNC_EN defined -> latency is 3 cycles.
